// File: rtl/edge_evt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edge_evt_pkg
// Description : Shared types, default sizes and the round-robin pick helper
//               for the edge event arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package edge_evt_pkg;

    localparam int N_CH_DEF = 4;
    localparam int TS_W_DEF = 16;
    localparam int CH_W_DEF = $clog2(N_CH_DEF);

    // The pick helper works on the largest supported channel count.
    localparam int RR_MAX   = 16;
    localparam int RR_IDX_W = 4;

    typedef struct packed {
        logic [CH_W_DEF-1:0] ch;
        logic                rise;
        logic [TS_W_DEF-1:0] stamp;
    } evt_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set request at or above ptr, wrapping at n.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   req,
                                         input logic [RR_IDX_W-1:0] ptr,
                                         input int                  n);
        rr_pick_t          res;
        logic [RR_IDX_W:0] cand;
        res.found = 1'b0;
        res.idx   = '0;
        for (int k = 0; k < RR_MAX; k++) begin
            if (k < n && !res.found) begin
                cand = {1'b0, ptr} + (RR_IDX_W+1)'(k);
                if (cand >= (RR_IDX_W+1)'(n)) begin
                    cand = cand - (RR_IDX_W+1)'(n);
                end
                if (req[cand[RR_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = cand[RR_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_event_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin selector. Returns the first request
//               at or above the pointer (with wrap) as one-hot and index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import edge_evt_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
)(
    input  logic [N_CH-1:0] i_req,
    input  logic [CH_W-1:0] i_ptr,
    output logic [N_CH-1:0] o_grant,
    output logic [CH_W-1:0] o_idx,
    output logic            o_any
);

    rr_pick_t w_pick;

    // Search the widened request vector starting at the pointer.
    always_comb begin
        w_pick = rr_pick(RR_MAX'(i_req), RR_IDX_W'(i_ptr), N_CH);
    end

    assign o_any = w_pick.found;
    assign o_idx = w_pick.idx[CH_W-1:0];

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_grant
        assign o_grant[gi] = w_pick.found && (w_pick.idx == RR_IDX_W'(gi));
    end

endmodule
`default_nettype wire

// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : edge_event_arbiter
// Description : Per-channel rise/fall edge detection with sticky timestamped
//               pending events, overflow flags, and a round-robin scheduler
//               feeding one valid/ready event channel.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int CH_W = $clog2(N_CH),
    parameter int TS_W = TS_W_DEF
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sig_in,
    input  logic [N_CH-1:0] rise_en,
    input  logic [N_CH-1:0] fall_en,
    input  logic [N_CH-1:0] ovf_clr,
    input  logic            evt_ready,
    output logic            evt_valid,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_rise,
    output logic [TS_W-1:0] evt_stamp,
    output logic [N_CH-1:0] pend,
    output logic [N_CH-1:0] ovf
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [CH_W-1:0] c_last_ch = CH_W'(N_CH - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_load;
    logic            w_take;

    logic [N_CH-1:0] r_prev;
    logic [N_CH-1:0] r_pend;
    logic [N_CH-1:0] r_ovf;
    logic [N_CH-1:0] r_kind;
    logic [TS_W-1:0] r_stamp [N_CH];
    logic [TS_W-1:0] r_ts;
    logic [CH_W-1:0] r_rr_ptr;
    logic [CH_W-1:0] r_evt_ch;
    logic            r_evt_rise;
    logic [TS_W-1:0] r_evt_stamp;

    logic [N_CH-1:0] w_rose;
    logic [N_CH-1:0] w_fell;
    logic [N_CH-1:0] w_edge;
    logic [N_CH-1:0] w_grant_oh;
    logic [CH_W-1:0] w_grant_idx;
    logic            w_any;
    logic [N_CH-1:0] w_clr;
    logic [N_CH-1:0] w_capture;
    logic [N_CH-1:0] w_ovf_set;
    logic [CH_W-1:0] w_rr_nxt;

    // Qualified edges against the previous sample.
    assign w_rose    = ~r_prev & sig_in & rise_en;
    assign w_fell    = r_prev & ~sig_in & fall_en;
    assign w_edge    = w_rose | w_fell;

    // A slot being granted this cycle is free for a new capture.
    assign w_take    = w_load & w_any;
    assign w_clr     = w_take ? w_grant_oh : '0;
    assign w_capture = w_edge & (~r_pend | w_clr);
    assign w_ovf_set = w_edge & r_pend & ~w_clr;
    assign w_rr_nxt  = (w_grant_idx == c_last_ch) ? '0 : w_grant_idx + 1'b1;

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr_arbiter (
        .i_req   (r_pend),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant_oh),
        .o_idx   (w_grant_idx),
        .o_any   (w_any)
    );

    // Previous sample; loading the live value in reset avoids a false edge on release.
    always_ff @(posedge clk) begin
        r_prev <= sig_in;
    end

    // Free-running timestamp counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // Pending and overflow flags; a fresh overflow beats a clear pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_ovf  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_edge;
            r_ovf  <= (r_ovf & ~ovf_clr) | w_ovf_set;
        end
    end

    // Stored kind and stamp per channel; only meaningful while pending.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (w_capture[i]) begin
                r_kind[i]  <= w_rose[i];
                r_stamp[i] <= r_ts;
            end
        end
    end

    // Output stage state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output stage loads whenever empty or the presented event is accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = (r_state == ST_EMPTY) || evt_ready;
        if (w_load) begin
            w_state_nxt = w_any ? ST_FULL : ST_EMPTY;
        end
    end

    // Presented event registers and round-robin pointer update on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt_ch    <= '0;
            r_evt_rise  <= 1'b0;
            r_evt_stamp <= '0;
            r_rr_ptr    <= '0;
        end else if (w_take) begin
            r_evt_ch    <= w_grant_idx;
            r_evt_rise  <= r_kind[w_grant_idx];
            r_evt_stamp <= r_stamp[w_grant_idx];
            r_rr_ptr    <= w_rr_nxt;
        end
    end

    assign evt_valid = (r_state == ST_FULL);
    assign evt_ch    = r_evt_ch;
    assign evt_rise  = r_evt_rise;
    assign evt_stamp = r_evt_stamp;
    assign pend      = r_pend;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_event_arbiter
// Description : Self-checking bench for edge_event_arbiter: directed tables,
//               hand sequences and random traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_event_arbiter;
    import edge_evt_pkg::*;

    localparam int N   = 4;
    localparam int TSW = 16;

    logic           clk       = 1'b0;
    logic           rst       = 1'b1;
    logic [N-1:0]   sig_in    = '0;
    logic [N-1:0]   rise_en   = '0;
    logic [N-1:0]   fall_en   = '0;
    logic [N-1:0]   ovf_clr   = '0;
    logic           evt_ready = 1'b0;
    logic           evt_valid;
    logic [1:0]     evt_ch;
    logic           evt_rise;
    logic [TSW-1:0] evt_stamp;
    logic [N-1:0]   pend;
    logic [N-1:0]   ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    edge_event_arbiter #(.N_CH(N), .CH_W(2), .TS_W(TSW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .rise_en   (rise_en),
        .fall_en   (fall_en),
        .ovf_clr   (ovf_clr),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch),
        .evt_rise  (evt_rise),
        .evt_stamp (evt_stamp),
        .pend      (pend),
        .ovf       (ovf)
    );

    // Presented event must not change while stalled.
    a_hold: assert property (@(posedge clk)
        $past(evt_valid && !evt_ready && !rst) |-> $stable({evt_ch, evt_rise, evt_stamp}));
    // A new grant must come from a pending channel.
    a_grant_pend: assert property (@(posedge clk)
        ($past(!rst && (!evt_valid || evt_ready)) && evt_valid) |-> ((($past(pend) >> evt_ch) & 4'd1) != 4'd0));
    a_rose: assert property (@(posedge clk)
        ($rose(evt_valid) && $past(!rst)) |-> ($past(pend) != 4'd0));
    a_fell: assert property (@(posedge clk)
        ($fell(evt_valid) && $past(!rst)) |-> $past(evt_ready));

    // ---------------- reference model ----------------
    bit   m_prev [N];
    bit   m_has  [N];
    evt_t m_ev   [N];
    bit   m_ov   [N];
    bit   m_full;
    evt_t m_out;
    int   m_ptr;
    int   m_ts;

    task automatic model_step(input logic [3:0] s, input logic [3:0] ren, input logic [3:0] fen,
                              input logic [3:0] oclr, input logic rdy, input logic r);
        int g;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_prev[i] = s[i];
                m_has[i]  = 1'b0;
                m_ov[i]   = 1'b0;
            end
            m_full = 1'b0;
            m_out  = '0;
            m_ptr  = 0;
            m_ts   = 0;
        end else begin
            if (!m_full || rdy) begin
                g = -1;
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && m_has[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
                if (g >= 0) begin
                    m_out    = m_ev[g];
                    m_has[g] = 1'b0;
                    m_ptr    = (g + 1) % N;
                    m_full   = 1'b1;
                end else begin
                    m_full = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                bit up, dn, newov;
                up    = !m_prev[i] && s[i] && ren[i];
                dn    = m_prev[i] && !s[i] && fen[i];
                newov = 1'b0;
                if (up || dn) begin
                    if (!m_has[i]) begin
                        m_has[i]      = 1'b1;
                        m_ev[i].ch    = 2'(i);
                        m_ev[i].rise  = up;
                        m_ev[i].stamp = 16'(m_ts);
                    end else begin
                        newov = 1'b1;
                    end
                end
                m_ov[i]   = newov || (m_ov[i] && !oclr[i]);
                m_prev[i] = s[i];
            end
            m_ts = (m_ts + 1) % 65536;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [3:0] ep, eo;
        for (int i = 0; i < N; i++) begin
            ep[i] = m_has[i];
            eo[i] = m_ov[i];
        end
        chk("model_valid", int'(evt_valid), int'(m_full));
        chk("model_pend", int'(pend), int'(ep));
        chk("model_ovf", int'(ovf), int'(eo));
        if (m_full) begin
            chk("model_ch", int'(evt_ch), int'(m_out.ch));
            chk("model_rise", int'(evt_rise), int'(m_out.rise));
            chk("model_stamp", int'(evt_stamp), int'(m_out.stamp));
        end
    endtask

    task automatic step(input logic [3:0] s, input logic [3:0] ren, input logic [3:0] fen,
                        input logic [3:0] oclr, input logic rdy, input logic r);
        sig_in    = s;
        rise_en   = ren;
        fall_en   = fen;
        ovf_clr   = oclr;
        evt_ready = rdy;
        rst       = r;
        model_step(s, ren, fen, oclr, rdy, r);
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct packed {
        logic [3:0] sig;
        logic [3:0] ren;
        logic [3:0] fen;
        logic       rdy;
        logic       valid;
        logic [1:0] ch;
        logic       rise;
        logic [3:0] pend;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int t1, t2;
        logic [3:0] rs, rren, rfen, roclr;
        logic rrdy, rrst;

        // Multi-edge table: simultaneous falls, then a wrapped pair of rises.
        tbl[0] = '{4'b1110, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[1] = '{4'b0000, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1110};
        tbl[2] = '{4'b0000, 4'h0, 4'hF, 1'b1, 1'b1, 2'd1, 1'b0, 4'b1100};
        tbl[3] = '{4'b0000, 4'h0, 4'hF, 1'b1, 1'b1, 2'd2, 1'b0, 4'b1000};
        tbl[4] = '{4'b0000, 4'h0, 4'hF, 1'b1, 1'b1, 2'd3, 1'b0, 4'b0000};
        tbl[5] = '{4'b0011, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0011};
        tbl[6] = '{4'b0011, 4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0010};
        tbl[7] = '{4'b0011, 4'hF, 4'hF, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0000};
        tbl[8] = '{4'b0011, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};

        // Reset with lines already high, then idle: no events.
        for (int k = 0; k < 3; k++) step(4'b0110, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1);
        chk("rst_stamp", int'(evt_stamp), 0);
        chk("rst_ch", int'(evt_ch), 0);
        for (int k = 0; k < 10; k++) begin
            step(4'b0110, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
            chk("idle_valid", int'(evt_valid), 0);
            chk("idle_pend", int'(pend), 0);
        end

        // Single fall on ch0 sampled at timestamp 0x20.
        for (int k = 10; k < 32; k++) step(4'b0111, 4'h0, 4'h1, 4'h0, 1'b1, 1'b0);
        step(4'b0110, 4'h0, 4'h1, 4'h0, 1'b1, 1'b0);
        chk("fall_pend", int'(pend), 4'b0001);
        chk("fall_valid_early", int'(evt_valid), 0);
        step(4'b0110, 4'h0, 4'h1, 4'h0, 1'b1, 1'b0);
        chk("fall_valid", int'(evt_valid), 1);
        chk("fall_ch", int'(evt_ch), 0);
        chk("fall_rise", int'(evt_rise), 0);
        chk("fall_stamp", int'(evt_stamp), 16'h0020);
        step(4'b0110, 4'h0, 4'h1, 4'h0, 1'b1, 1'b0);
        chk("fall_done", int'(evt_valid), 0);

        for (int r = 0; r < 9; r++) begin
            step(tbl[r].sig, tbl[r].ren, tbl[r].fen, 4'h0, tbl[r].rdy, 1'b0);
            chk("tbl_valid", int'(evt_valid), int'(tbl[r].valid));
            chk("tbl_pend", int'(pend), int'(tbl[r].pend));
            if (tbl[r].valid) begin
                chk("tbl_ch", int'(evt_ch), int'(tbl[r].ch));
                chk("tbl_rise", int'(evt_rise), int'(tbl[r].rise));
            end
        end

        // Stall: fall presented, rise pending, second fall overflows.
        t1 = m_ts;
        step(4'b0010, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        chk("st_pend1", int'(pend), 4'b0001);
        t2 = m_ts;
        step(4'b0011, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        chk("st_valid", int'(evt_valid), 1);
        chk("st_rise0", int'(evt_rise), 0);
        chk("st_pend2", int'(pend), 4'b0001);
        chk("st_ovf0", int'(ovf), 4'b0000);
        step(4'b0010, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        chk("st_ovf1", int'(ovf), 4'b0001);
        chk("st_hold_stamp", int'(evt_stamp), t1);
        chk("st_hold_rise", int'(evt_rise), 0);
        step(4'b0010, 4'hF, 4'hF, 4'h1, 1'b0, 1'b0);
        chk("st_ovf_clr", int'(ovf), 4'b0000);
        step(4'b0010, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
        chk("st_deliver_rise", int'(evt_rise), 1);
        chk("st_deliver_stamp", int'(evt_stamp), t2);
        chk("st_deliver_pend", int'(pend), 4'b0000);
        step(4'b0010, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
        chk("st_empty", int'(evt_valid), 0);

        // Recapture on the channel being granted.
        step(4'b0110, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        step(4'b0110, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        chk("rc_ch", int'(evt_ch), 2);
        step(4'b0010, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        chk("rc_pend", int'(pend), 4'b0100);
        step(4'b0110, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
        chk("rc_fall", int'(evt_rise), 0);
        chk("rc_repend", int'(pend), 4'b0100);
        chk("rc_no_ovf", int'(ovf), 4'b0000);
        step(4'b0110, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
        chk("rc_next_ch", int'(evt_ch), 2);
        chk("rc_next_rise", int'(evt_rise), 1);
        step(4'b0110, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
        chk("rc_empty", int'(evt_valid), 0);

        // Reset while an event is presented and others pend.
        step(4'b0100, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        step(4'b0100, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        step(4'b1110, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        chk("mr_pre_pend", int'(pend), 4'b1010);
        chk("mr_pre_valid", int'(evt_valid), 1);
        step(4'b1110, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1);
        chk("mr_valid", int'(evt_valid), 0);
        chk("mr_pend", int'(pend), 0);
        chk("mr_ovf", int'(ovf), 0);
        chk("mr_stamp", int'(evt_stamp), 0);
        step(4'b1111, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
        chk("mr_post_pend", int'(pend), 4'b0001);
        step(4'b1111, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
        chk("mr_ts0_stamp", int'(evt_stamp), 0);
        chk("mr_ts0_ch", int'(evt_ch), 0);
        step(4'b1111, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
        chk("mr_quiet", int'(evt_valid), 0);

        // Random traffic against the model.
        rs   = 4'b1111;
        rren = 4'hF;
        rfen = 4'hF;
        for (int c = 0; c < 4000; c++) begin
            rs = rs ^ (4'($urandom) & 4'($urandom));
            if ($urandom_range(0, 15) == 0) rren = 4'($urandom);
            if ($urandom_range(0, 15) == 0) rfen = 4'($urandom);
            roclr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            rrdy  = ((c % 200) < 80) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rrst  = ($urandom_range(0, 499) == 0);
            step(rs, rren, rfen, roclr, rrdy, rrst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
